reg_uart_resp_tx: RTL and testbench

REG_UART_RESP_TX -- requirements
Module: reg_uart_resp_tx

---
 rtl/reg_uart_resp_tx_pkg.sv | 16 +
 rtl/reg_uart_resp_tx_byte.sv | 98 +++++++++
 rtl/reg_uart_resp_tx.sv | 93 +++++++++
 tb/tb_reg_uart_resp_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_uart_resp_tx_pkg.sv
// Shared constants and serializer state encoding for the register-response UART framer.
package reg_uart_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] STATUS_OK   = 8'h00;
    localparam logic [7:0] STATUS_ERR  = 8'hEE;
    localparam int         FRAME_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/reg_uart_resp_tx_byte.sv
// 8N1 byte serializer, every bit DIV cycles; the start bit appears the cycle after acceptance.
// byte_ready is high in IDLE and in the final cycle of a stop bit, so bytes can chain with no gap.
module uart_tx_byte
    import reg_uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx,
    output logic       idle
);

    localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             tx_nxt;
    logic             bit_end;

    assign bit_end    = (cnt == CNT_LAST);
    assign idle       = (state == ST_IDLE);
    assign byte_ready = idle | ((state == ST_STOP) & bit_end);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_end ? '0 : cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        tx_nxt      = tx;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                tx_nxt  = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                    tx_nxt      = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        // A new byte overrides the IDLE/stop-end transition so the next start bit follows directly.
        if (byte_valid && byte_ready) begin
            state_nxt   = ST_START;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            shreg_nxt   = byte_data;
            tx_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
        end
    end

endmodule

// File: rtl/reg_uart_resp_tx.sv
// Frames a register read response as 8 UART bytes (sync, status, addr, data MSB first, checksum).
// Accepts one response per frame; rsp_ready is held low from capture until the last stop bit ends.
module reg_uart_resp_tx
    import reg_uart_pkg::*;
#(
    parameter int CLK_FREQ = 125000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [7:0]  rsp_addr,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        uart_tx,
    output logic        busy
);

    localparam int DIV = CLK_FREQ / BAUD;

    if (DIV < 2) begin : g_div_check
        $error("reg_uart_resp_tx: CLK_FREQ/BAUD must be at least 2");
    end

    logic [7:0]  cap_addr;
    logic [31:0] cap_data;
    logic        cap_err;
    logic [2:0]  byte_idx;
    logic        ser_idle;
    logic        ser_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [7:0]  status;
    logic [7:0]  checksum;
    logic        xfer;

    assign rsp_ready = ser_idle & ~rst;
    assign busy      = ~rsp_ready;
    assign xfer      = rsp_valid & rsp_ready;

    assign status   = cap_err ? STATUS_ERR : STATUS_OK;
    assign checksum = status + cap_addr + cap_data[31:24] + cap_data[23:16]
                    + cap_data[15:8] + cap_data[7:0];

    // byte_idx names the byte on the wire; mid-frame the mux offers the one after it.
    assign byte_valid = ser_idle ? xfer : (byte_idx != 3'(FRAME_BYTES - 1));

    always_comb begin
        byte_data = SYNC_BYTE;
        if (!ser_idle) begin
            case (byte_idx)
                3'd0:    byte_data = status;
                3'd1:    byte_data = cap_addr;
                3'd2:    byte_data = cap_data[31:24];
                3'd3:    byte_data = cap_data[23:16];
                3'd4:    byte_data = cap_data[15:8];
                3'd5:    byte_data = cap_data[7:0];
                3'd6:    byte_data = checksum;
                default: byte_data = SYNC_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_err  <= 1'b0;
            byte_idx <= '0;
        end else if (xfer) begin
            cap_addr <= rsp_addr;
            cap_data <= rsp_data;
            cap_err  <= rsp_err;
            byte_idx <= '0;
        end else if (!ser_idle && ser_ready && byte_valid) begin
            byte_idx <= byte_idx + 3'd1;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (ser_ready),
        .tx         (uart_tx),
        .idle       (ser_idle)
    );

endmodule

// File: tb/tb_reg_uart_resp_tx.sv
// Scoreboard bench: expected frame bytes are queued at each transfer and checked cycle by cycle on uart_tx.
module tb_reg_uart_resp_tx;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        a_valid, a_ready, a_err, a_tx, a_busy;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready, b_err, b_tx, b_busy;
    logic [7:0]  b_addr;
    logic [31:0] b_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    reg_uart_resp_tx #(.CLK_FREQ(1000), .BAUD(100)) dut_a (
        .clk(clk), .rst(rst_a), .rsp_valid(a_valid), .rsp_ready(a_ready),
        .rsp_addr(a_addr), .rsp_data(a_data), .rsp_err(a_err),
        .uart_tx(a_tx), .busy(a_busy)
    );

    reg_uart_resp_tx dut_b (
        .clk(clk), .rst(rst_b), .rsp_valid(b_valid), .rsp_ready(b_ready),
        .rsp_addr(b_addr), .rsp_data(b_data), .rsp_err(b_err),
        .uart_tx(b_tx), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_byte(input int n, input logic [7:0] ad,
                                              input logic [31:0] d, input logic e);
        logic [7:0] fb [8];
        fb[0] = 8'hA5;
        fb[1] = e ? 8'hEE : 8'h00;
        fb[2] = ad;
        fb[3] = d[31:24];
        fb[4] = d[23:16];
        fb[5] = d[15:8];
        fb[6] = d[7:0];
        fb[7] = 8'h00;
        for (int i = 1; i <= 6; i++) fb[7] = fb[7] + fb[i];
        return fb[n];
    endfunction

    task automatic set_rsp(input bit inst, input logic v, input logic [7:0] ad,
                           input logic [31:0] d, input logic e);
        if (inst) begin b_valid = v; b_addr = ad; b_data = d; b_err = e; end
        else      begin a_valid = v; a_addr = ad; a_data = d; a_err = e; end
    endtask

    // Present a response, wait (bounded) for the transfer edge, queue the expected bytes.
    task automatic send(input bit inst, input logic [7:0] ad, input logic [31:0] d,
                        input logic e, input bit hold, input string tag);
        int n = 0;
        set_rsp(inst, 1'b1, ad, d, e);
        while ((inst ? b_ready : a_ready) !== 1'b1 && n < 200000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(inst ? b_ready : a_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (inst) qb.push_back(model_byte(i, ad, d, e));
            else      qa.push_back(model_byte(i, ad, d, e));
        end
        @(negedge clk);
        if (!hold) set_rsp(inst, 1'b0, ad, d, e);
    endtask

    // Entered in the cycle after the transfer; compares uart_tx against the expected waveform every cycle.
    task automatic rx_frame(input int div, input bit inst, input string tag);
        int         mism = 0;
        int         low  = 0;
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       want;
        logic       t;
        for (int b = 0; b < 8; b++) begin
            got = 8'h00;
            if ((inst ? qb.size() : qa.size()) == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
                exp_b = 8'h00;
            end else if (inst) begin
                exp_b = qb.pop_front();
            end else begin
                exp_b = qa.pop_front();
            end
            for (int k = 0; k < 10; k++) begin
                want = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_b[k-1];
                for (int c = 0; c < div; c++) begin
                    t = inst ? b_tx : a_tx;
                    if (t !== want) mism++;
                    if (c == div / 2 && k >= 1 && k <= 8) got[k-1] = t;
                    if ((inst ? b_ready : a_ready) === 1'b0) low++;
                    @(negedge clk);
                end
            end
            chk($sformatf("%s_byte%0d", tag, b), 32'(got), 32'(exp_b));
        end
        chk({tag, "_wave_mism"}, mism, 32'd0);
        chk({tag, "_rdy_low_cycles"}, low, 80 * div);
        chk({tag, "_rdy_after"}, 32'(inst ? b_ready : a_ready), 32'd1);
        chk({tag, "_busy_after"}, 32'(inst ? b_busy : a_busy), 32'd0);
        chk({tag, "_tx_after"}, 32'(inst ? b_tx : a_tx), 32'd1);
    endtask

    task automatic run_a();
        send(1'b0, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, "s1");
        rx_frame(10, 1'b0, "s1");

        send(1'b0, 8'h7F, 32'h00000000, 1'b1, 1'b0, "s2");
        rx_frame(10, 1'b0, "s2");

        // Valid stays high; the second payload is presented right after the first capture.
        send(1'b0, 8'h3C, 32'h11223344, 1'b0, 1'b1, "s3a");
        set_rsp(1'b0, 1'b1, 8'hC3, 32'h8899AABB, 1'b1);
        rx_frame(10, 1'b0, "s3a");
        send(1'b0, 8'hC3, 32'h8899AABB, 1'b1, 1'b0, "s3b");
        rx_frame(10, 1'b0, "s3b");

        send(1'b0, 8'h34, 32'hCAFEF00D, 1'b0, 1'b0, "s4");
        repeat (249) @(negedge clk);
        chk("s4_tx_before_rst", 32'(a_tx), 32'd0);
        rst_a = 1'b1;
        #1;
        chk("s4_tx_on_rst", 32'(a_tx), 32'd1);
        chk("s4_rdy_on_rst", 32'(a_ready), 32'd0);
        chk("s4_busy_on_rst", 32'(a_busy), 32'd1);
        @(negedge clk);
        chk("s4_tx_in_rst", 32'(a_tx), 32'd1);
        rst_a = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("s4_rdy_after_rst", 32'(a_ready), 32'd1);
        chk("s4_tx_after_rst", 32'(a_tx), 32'd1);
        send(1'b0, 8'h34, 32'h0BADF00D, 1'b1, 1'b0, "s4b");
        rx_frame(10, 1'b0, "s4b");

        send(1'b0, 8'hA1, 32'h76543210, 1'b0, 1'b0, "s5");
        set_rsp(1'b0, 1'b0, 8'h5E, 32'hFFFFFFFF, 1'b1);
        repeat (300) @(negedge clk);
        set_rsp(1'b0, 1'b0, 8'h00, 32'h13572468, 1'b0);
        qa.push_front(8'h00);
        void'(qa.pop_front());
        rx_frame_tail_s5();
        chk("a_sb_left", qa.size(), 32'd0);
    endtask

    // The first 300 cycles of scenario 5 were spent changing inputs; verify the remaining bytes.
    task automatic rx_frame_tail_s5();
        int         mism = 0;
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       want;
        for (int b = 3; b < 8; b++) begin
            got = 8'h00;
            if (b == 3) begin
                for (int i = 0; i < 3; i++) void'(qa.pop_front());
            end
            exp_b = (qa.size() != 0) ? qa.pop_front() : 8'h00;
            for (int k = 0; k < 10; k++) begin
                want = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_b[k-1];
                for (int c = 0; c < 10; c++) begin
                    if (a_tx !== want) mism++;
                    if (c == 5 && k >= 1 && k <= 8) got[k-1] = a_tx;
                    @(negedge clk);
                end
            end
            chk($sformatf("s5_byte%0d", b), 32'(got), 32'(exp_b));
        end
        chk("s5_wave_mism", mism, 32'd0);
        chk("s5_rdy_after", 32'(a_ready), 32'd1);
    endtask

    task automatic run_b();
        send(1'b1, 8'h5A, 32'h01234567, 1'b0, 1'b0, "s6");
        rx_frame(1085, 1'b1, "s6");
        chk("b_sb_left", qb.size(), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_rsp(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_rsp(1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_a_tx", 32'(a_tx), 32'd1);
        chk("rst_a_rdy", 32'(a_ready), 32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd1);
        chk("rst_b_tx", 32'(b_tx), 32'd1);
        chk("rst_b_rdy", 32'(b_ready), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_a_rdy", 32'(a_ready), 32'd1);
        chk("post_rst_a_busy", 32'(a_busy), 32'd0);
        chk("post_rst_b_rdy", 32'(b_ready), 32'd1);
        fork
            run_a();
            run_b();
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
